// File: rtl/sevenseg_pkg.sv
// Shared constants, slot encodings and the BCD to seven-segment decode for the
// scanned three-digit display.
package sevenseg_pkg;

    // Segment patterns, active-high, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // Scan slot index; the fourth code of the 2-bit field is never a legal slot
    typedef enum logic [1:0] {
        SLOT_SEC_LO = 2'd0,
        SLOT_SEC_HI = 2'd1,
        SLOT_MIN_LO = 2'd2
    } slot_e;

    // Non-BCD values render as a dash so a bad upstream digit is visible
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] pattern;
        case (bcd)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-high seven-segment decoder.
module bcd_to_7seg
    import sevenseg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Pure table lookup, shared with the package function
    always_comb begin
        seg = bcd_to_seg(bcd);
    end

endmodule

// File: rtl/sevenseg_scan_mux.sv
// Time-multiplexed driver for a 3-digit common-anode seven-segment display.
// Digits are snapshotted once per frame, each slot opens with an all-off
// blanking window, and the min slot carries a tick-toggled decimal point.
module sevenseg_scan_mux
    import sevenseg_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int ACTIVE_LOW   = 1,
    parameter int BLANK_LZ     = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sec_low_digit,
    input  logic [2:0] sec_high_digit,
    input  logic [3:0] min_low_digit,
    input  logic       dp_tick,
    output logic [6:0] seg,
    output logic       dp,
    output logic [2:0] an
);

    localparam int            CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic          POL       = (ACTIVE_LOW != 0);
    localparam logic          LZ_EN     = (BLANK_LZ != 0);

    logic [CW-1:0] cnt;
    logic          wrap;
    slot_e         idx;
    slot_e         idx_next;
    logic [3:0]    snap_sec_lo;
    logic [2:0]    snap_sec_hi;
    logic [3:0]    snap_min_lo;
    logic          dp_state;

    logic          blank;
    logic [3:0]    digit;
    logic [6:0]    seg_dec;
    logic [2:0]    an_c;
    logic [6:0]    seg_c;
    logic          dp_c;

    assign wrap = (cnt == CNT_MAX);

    // Slot counter: free-running 0..SCAN_DIV-1
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Next slot: advance at counter wrap, recover an illegal code to slot 0
    always_comb begin
        idx_next = idx;
        case (idx)
            SLOT_SEC_LO: if (wrap) idx_next = SLOT_SEC_HI;
            SLOT_SEC_HI: if (wrap) idx_next = SLOT_MIN_LO;
            SLOT_MIN_LO: if (wrap) idx_next = SLOT_SEC_LO;
            default:     idx_next = SLOT_SEC_LO;
        endcase
    end

    // Slot index register
    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= SLOT_SEC_LO;
        end else begin
            idx <= idx_next;
        end
    end

    // Frame snapshot: capture all digits on the edge that closes the min slot
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_sec_lo <= '0;
            snap_sec_hi <= '0;
            snap_min_lo <= '0;
        end else if (wrap && (idx == SLOT_MIN_LO)) begin
            snap_sec_lo <= sec_low_digit;
            snap_sec_hi <= sec_high_digit;
            snap_min_lo <= min_low_digit;
        end
    end

    // Decimal-point state: toggle per tick, reset takes priority
    always_ff @(posedge clk) begin
        if (reset) begin
            dp_state <= 1'b0;
        end else if (dp_tick) begin
            dp_state <= ~dp_state;
        end
    end

    // Select the snapshot digit for the current slot
    always_comb begin
        digit = '0;
        case (idx)
            SLOT_SEC_LO: digit = snap_sec_lo;
            SLOT_SEC_HI: digit = {1'b0, snap_sec_hi};
            SLOT_MIN_LO: digit = snap_min_lo;
            default:     digit = '0;
        endcase
    end

    bcd_to_7seg u_dec (
        .bcd (digit),
        .seg (seg_dec)
    );

    // Active-high output image: blanking, anode one-hot, leading-zero and dp
    always_comb begin
        blank = (cnt < BLANK_END);
        an_c  = '0;
        seg_c = SEG_OFF;
        dp_c  = 1'b0;
        if (!blank) begin
            case (idx)
                SLOT_SEC_LO: an_c = 3'b001;
                SLOT_SEC_HI: an_c = 3'b010;
                SLOT_MIN_LO: an_c = 3'b100;
                default:     an_c = 3'b000;
            endcase
            if (LZ_EN && (idx == SLOT_MIN_LO) && (snap_min_lo == 4'd0)) begin
                seg_c = SEG_OFF;
            end else begin
                seg_c = seg_dec;
            end
            dp_c = (idx == SLOT_MIN_LO) && dp_state;
        end
    end

    // Output register with polarity applied to an, seg and dp together
    always_ff @(posedge clk) begin
        if (reset) begin
            {an, seg, dp} <= {11{POL}};
        end else begin
            {an, seg, dp} <= {an_c, seg_c, dp_c} ^ {11{POL}};
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_mux.sv
// Bench for sevenseg_scan_mux: three instances (active-high, active-low,
// leading-zero blanking) share stimulus and are compared every cycle against
// a time-arithmetic model, plus literal pin checks at known frame positions.
module tb_sevenseg_scan_mux;

    localparam int SD = 8;
    localparam int BC = 2;
    localparam int FR = 3 * SD;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sec_low_digit;
    logic [2:0] sec_high_digit;
    logic [3:0] min_low_digit;
    logic       dp_tick;

    logic [6:0] seg0, seg1, seg2;
    logic       dp0, dp1, dp2;
    logic [2:0] an0, an1, an2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sevenseg_scan_mux #(.SCAN_DIV(SD), .BLANK_CYCLES(BC), .ACTIVE_LOW(0), .BLANK_LZ(0)) dut0 (
        .clk(clk), .reset(reset), .sec_low_digit(sec_low_digit), .sec_high_digit(sec_high_digit),
        .min_low_digit(min_low_digit), .dp_tick(dp_tick), .seg(seg0), .dp(dp0), .an(an0));
    sevenseg_scan_mux #(.SCAN_DIV(SD), .BLANK_CYCLES(BC), .ACTIVE_LOW(1), .BLANK_LZ(0)) dut1 (
        .clk(clk), .reset(reset), .sec_low_digit(sec_low_digit), .sec_high_digit(sec_high_digit),
        .min_low_digit(min_low_digit), .dp_tick(dp_tick), .seg(seg1), .dp(dp1), .an(an1));
    sevenseg_scan_mux #(.SCAN_DIV(SD), .BLANK_CYCLES(BC), .ACTIVE_LOW(0), .BLANK_LZ(1)) dut2 (
        .clk(clk), .reset(reset), .sec_low_digit(sec_low_digit), .sec_high_digit(sec_high_digit),
        .min_low_digit(min_low_digit), .dp_tick(dp_tick), .seg(seg2), .dp(dp2), .an(an2));

    logic [10:0] act [3];
    assign act[0] = {an0, seg0, dp0};
    assign act[1] = {an1, seg1, dp1};
    assign act[2] = {an2, seg2, dp2};

    bit cfg_al [3] = '{1'b0, 1'b1, 1'b0};
    bit cfg_lz [3] = '{1'b0, 1'b0, 1'b1};

    logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    // Model state: cycles since reset release, frame snapshot, dp toggle
    int          mt = 0;
    logic [3:0]  ms [3] = '{4'd0, 4'd0, 4'd0};
    bit          mdps = 1'b0;
    logic [10:0] exp_q [3];
    bit          have_exp = 1'b0;
    bit          done = 1'b0;

    function automatic logic [10:0] model_out(input bit al, input bit lz, input bit r, input int t,
                                              input logic [3:0] d0, input logic [3:0] d1,
                                              input logic [3:0] d2, input bit dps);
        logic [2:0] a;
        logic [6:0] s;
        logic       d;
        logic [3:0] dig;
        int         w;
        int         sl;
        a = '0; s = '0; d = 1'b0;
        if (!r) begin
            w  = t % SD;
            sl = (t / SD) % 3;
            if (w >= BC) begin
                a   = 3'(1 << sl);
                dig = (sl == 0) ? d0 : (sl == 1) ? d1 : d2;
                s   = (lz && sl == 2 && dig == 4'd0) ? 7'h00 : dec_tab[dig];
                d   = (sl == 2) && dps;
            end
        end
        return {a, s, d} ^ {11{al}};
    endfunction

    task automatic chk(input string nm, input logic [10:0] a, input logic [10:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, a, e);
        end
    endtask

    // Model: expected outputs after each edge come from the pre-edge state
    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++)
                exp_q[i] = model_out(cfg_al[i], cfg_lz[i], reset, mt, ms[0], ms[1], ms[2], mdps);
            if (reset) begin
                mt = 0;
                ms = '{4'd0, 4'd0, 4'd0};
                mdps = 1'b0;
            end else begin
                if (mt % FR == FR - 1) begin
                    ms[0] = sec_low_digit;
                    ms[1] = {1'b0, sec_high_digit};
                    ms[2] = min_low_digit;
                end
                mt++;
                if (dp_tick) mdps = ~mdps;
            end
            have_exp = 1'b1;
        end
    end

    // Per-cycle comparison of all three instances against the model
    initial begin
        forever begin
            @(negedge clk);
            if (have_exp && !done) begin
                chk("cyc_dut0", act[0], exp_q[0]);
                chk("cyc_dut1", act[1], exp_q[1]);
                chk("cyc_dut2", act[2], exp_q[2]);
            end
        end
    end

    int cur = -1;
    task automatic wait_t(input int target);
        repeat (target - cur) @(negedge clk);
        cur = target;
    endtask

    initial begin
        reset = 1'b1;
        sec_low_digit = 4'd3; sec_high_digit = 3'd4; min_low_digit = 4'd7;
        dp_tick = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_unlit_hi", act[0], 11'h000);
        chk("rst_unlit_lo", act[1], 11'h7FF);
        chk("model_rst_lo", exp_q[1], 11'h7FF);
        reset = 1'b0;
        cur = -1;

        wait_t(0);
        chk("first_blank_an", {8'h0, an0}, 11'h000);
        wait_t(2);
        chk("first_slot0", {an0, seg0, dp0}, {3'b001, 7'h3F, 1'b0});
        wait_t(26);
        chk("f2_slot0", {an0, seg0, dp0}, {3'b001, 7'h4F, 1'b0});
        chk("f2_slot0_lo", {an1, seg1, dp1}, {3'b110, 7'h30, 1'b1});
        chk("model_f2_slot0", exp_q[0], {3'b001, 7'h4F, 1'b0});
        wait_t(34);
        chk("f2_slot1", {an0, seg0, dp0}, {3'b010, 7'h66, 1'b0});
        wait_t(42);
        chk("f2_slot2", {an0, seg0, dp0}, {3'b100, 7'h07, 1'b0});
        chk("model_f2_slot2", exp_q[0], {3'b100, 7'h07, 1'b0});

        // Digit change inside a frame must wait for the next frame
        wait_t(50);
        sec_low_digit = 4'd5;
        wait_t(53);
        chk("midframe_hold", {an0, seg0, dp0}, {3'b001, 7'h4F, 1'b0});
        wait_t(74);
        chk("nextframe_new", {an0, seg0, dp0}, {3'b001, 7'h6D, 1'b0});

        // Non-BCD min digit, then zero min with leading-zero blanking
        min_low_digit = 4'd12;
        wait_t(114);
        chk("dash", {an0, seg0, dp0}, {3'b100, 7'h40, 1'b0});
        min_low_digit = 4'd0;
        wait_t(138);
        chk("lz_blank", {an2, seg2, dp2}, {3'b100, 7'h00, 1'b0});
        chk("lz_off_zero", {an0, seg0, dp0}, {3'b100, 7'h3F, 1'b0});

        // One dp pulse lights dp in the min slot, a second one clears it
        dp_tick = 1'b1;
        wait_t(139);
        dp_tick = 1'b0;
        wait_t(160);
        chk("dp_blank", {10'h0, dp0}, 11'h000);
        wait_t(162);
        chk("dp_lit", {an0, seg0, dp0}, {3'b100, 7'h3F, 1'b1});
        wait_t(163);
        dp_tick = 1'b1;
        wait_t(164);
        dp_tick = 1'b0;
        wait_t(166);
        chk("dp_second", {10'h0, dp0}, 11'h000);

        // Reset in the middle of the sec_high lit window
        wait_t(179);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_hi", act[0], 11'h000);
        chk("midrst_lo", act[1], 11'h7FF);
        reset = 1'b0;
        cur = -1;
        wait_t(1);
        chk("post_rst_blank", {8'h0, an0}, 11'h000);
        wait_t(2);
        chk("post_rst_slot0", {8'h0, an0}, 11'h001);

        // Randomized traffic, with occasional resets and dp ticks
        for (int n = 0; n < 900; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 150) == 0) reset = 1'b1;
            else if (reset && $urandom_range(0, 2) == 0) reset = 1'b0;
            if ($urandom_range(0, 9) == 0) begin
                sec_low_digit  = 4'($urandom_range(0, 15));
                sec_high_digit = 3'($urandom_range(0, 7));
                min_low_digit  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            end
            dp_tick = ($urandom_range(0, 11) == 0);
        end
        reset = 1'b0;
        dp_tick = 1'b0;
        repeat (2) @(negedge clk);
        done = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
